// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths, FSM state encoding and write-request record for the RF write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_arb_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 2 ** AW;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among N valid lines, search starts at ptr and wraps N-1 -> 0.
// Latency: purely combinational, no state (the pointer is owned by the caller).
// Backpressure: none; at most one grant bit set, gnt_vld low when nothing is valid.
// Ports: valid[N] in, ptr in, gnt[N] one-hot out, gnt_idx out, gnt_vld out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Walk the lines in priority order ptr, ptr+1, ... ; the first valid one wins.
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_vld && valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port among NREQ writeback sources, round-robin.
// Latency: transfer in cycle n -> RFWr/rd/DataWr registered and visible in cycle n+1.
// Backpressure: req_ready is the combinational one-hot grant; losers keep valid high until granted; 0 in reset/clear.
// Ports: CLK, RST_N (async, active-low); req_valid[NREQ], req_rd[NREQ*AW], req_data[NREQ*XLEN], req_ready[NREQ];
//        rd, DataWr, RFWr towards the register unit; init_busy high while the clear sequence runs.
// Build option: define RF_CLEAR_EN to clear x1..x(2**AW-1) after reset before serving requesters.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = rf_arb_pkg::XLEN,
  parameter int AW   = rf_arb_pkg::AW
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        rd,
  output logic [XLEN-1:0]      DataWr,
  output logic                 RFWr,
  output logic                 init_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr, ptr_nxt;
  logic [NREQ-1:0] gnt, ready_int;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic            in_init, clr_vld;
  logic [AW-1:0]   clr_rd;
  logic            wr_nxt;
  logic [AW-1:0]   rd_nxt, sel_rd;
  logic [XLEN-1:0] data_nxt, sel_data;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .valid   (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign sel_rd   = req_rd[int'(gnt_idx)*AW +: AW];
  assign sel_data = req_data[int'(gnt_idx)*XLEN +: XLEN];

`ifdef RF_CLEAR_EN
  state_t        state, state_nxt;
  // Next register to clear. Bit AW sets one cycle after the last clear write is issued,
  // which is the cycle the FSM uses to hand over to RUN.
  logic [AW:0]   clr_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= INIT;
      clr_cnt <= (AW+1)'(1);
    end else begin
      state <= state_nxt;
      if (clr_vld) clr_cnt <= clr_cnt + (AW+1)'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && clr_cnt[AW]) state_nxt = RUN;
  end

  assign in_init = (state == INIT);
  assign clr_vld = in_init && !clr_cnt[AW];
  assign clr_rd  = clr_cnt[AW-1:0];
`else
  assign in_init = 1'b0;
  assign clr_vld = 1'b0;
  assign clr_rd  = '0;
`endif

  always_comb begin
    ready_int = '0;
    ptr_nxt   = ptr;
    wr_nxt    = 1'b0;
    rd_nxt    = rd;
    data_nxt  = DataWr;
    if (clr_vld) begin
      wr_nxt   = 1'b1;
      rd_nxt   = clr_rd;
      data_nxt = '0;
    end else if (!in_init && gnt_vld) begin
      ready_int = gnt;
      ptr_nxt   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
      // x0 writes are accepted to keep the requester moving, but never reach the register unit.
      if (sel_rd != '0) begin
        wr_nxt   = 1'b1;
        rd_nxt   = sel_rd;
        data_nxt = sel_data;
      end
    end
  end

  // Grant is combinational from req_valid; force it low while reset is applied.
  assign req_ready = ready_int & {NREQ{RST_N}};
  assign init_busy = in_init;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr    <= '0;
      RFWr   <= 1'b0;
      rd     <= '0;
      DataWr <= '0;
    end else begin
      ptr    <= ptr_nxt;
      RFWr   <= wr_nxt;
      rd     <= rd_nxt;
      DataWr <= data_nxt;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed + random stimulus for rf_write_arbiter against a transaction-level model.
// Latency: model predicts grant in cycle n and the register-unit write in cycle n+1.
// Backpressure: requesters hold rd/data while valid && !ready, as the arbiter expects.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int NREQ  = 2;
  localparam int XW    = 32;
  localparam int AWID  = 5;
  localparam int NREGS = 1 << AWID;
`ifdef RF_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AWID-1:0] req_rd;
  logic [NREQ*XW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [AWID-1:0]      rd;
  logic [XW-1:0]        DataWr;
  logic                 RFWr;
  logic                 init_busy;

  rf_write_arbiter #(.NREQ(NREQ), .XLEN(XW), .AW(AWID)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rd        (rd),
    .DataWr    (DataWr),
    .RFWr      (RFWr),
    .init_busy (init_busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending request per source, rotating priority start, cycles since reset,
  // and the register-unit write the arbiter should be presenting.
  wr_req_t         pend [NREQ];
  int              n_chk = 0;
  int              n_fail = 0;
  int              mp;
  int              m_cyc;
  logic            m_rfwr;
  logic [AWID-1:0] m_rd;
  logic [XW-1:0]   m_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic reset_model();
    mp     = 0;
    m_cyc  = 0;
    m_rfwr = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic set_req(input int i, input logic [AWID-1:0] r, input logic [XW-1:0] d);
    pend[i].rd                = r;
    pend[i].data              = d;
    req_rd[i*AWID +: AWID]    = r;
    req_data[i*XW +: XW]      = d;
    req_valid[i]              = 1'b1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_RFWr"},      64'(RFWr),      64'd0);
    chk({tag, "_rd"},        64'(rd),        64'd0);
    chk({tag, "_DataWr"},    64'(DataWr),    64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_init_busy"}, 64'(init_busy), 64'(CLR));
  endtask

  // One clock: check grant before the edge, advance the model, check the registered write after it.
  task automatic cycle(input string tag, output logic [NREQ-1:0] obs_rdy);
    int              g;
    logic            busy;
    logic [AWID-1:0] grd;
    logic [XW-1:0]   gdat;
    @(negedge CLK);
    busy    = CLR && (m_cyc < NREGS);
    g       = busy ? -1 : model_grant(req_valid, mp);
    obs_rdy = req_ready;
    chk({tag, "_ready"}, 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    chk({tag, "_init_busy"}, 64'(init_busy), 64'(busy));
    if (g >= 0) begin
      grd  = pend[g].rd;
      gdat = pend[g].data;
    end else begin
      grd  = '0;
      gdat = '0;
    end
    @(posedge CLK);
    #1;
    if (g >= 0) begin
      mp           = (g + 1) % NREQ;
      req_valid[g] = 1'b0;
      m_rfwr       = (grd != '0);
      if (grd != '0) begin
        m_rd   = grd;
        m_data = gdat;
      end
    end else if (CLR && (m_cyc + 1 < NREGS)) begin
      m_rfwr = 1'b1;
      m_rd   = AWID'(m_cyc + 1);
      m_data = '0;
    end else begin
      m_rfwr = 1'b0;
    end
    m_cyc++;
    chk({tag, "_RFWr"},   64'(RFWr),   64'(m_rfwr));
    chk({tag, "_rd"},     64'(rd),     64'(m_rd));
    chk({tag, "_DataWr"}, 64'(DataWr), 64'(m_data));
  endtask

  initial begin
    logic [NREQ-1:0] obs, prev;
    RST_N     = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    reset_model();
    set_req(0, AWID'(9), 32'h1111_2222);
    #1;
    check_reset_outs("rst_init");
    req_valid = '0;
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    reset_model();

`ifdef RF_CLEAR_EN
    // Clear sequence interrupted by reset, then run to completion with a request pending throughout.
    set_req(0, AWID'(7), 32'hA5A5_5A5A);
    for (int i = 0; i < 10; i++) cycle("t5_pre", obs);
    #1 RST_N = 1'b0;
    #1 check_reset_outs("t6_midinit");
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    reset_model();
    for (int i = 0; i < NREGS + 2; i++) begin
      cycle("t5_clear", obs);
      if (i == NREGS) chk("t5_first_run_grant", 64'(obs), 64'd1);
    end
`endif

    // Idle: nothing valid, no writes.
    for (int i = 0; i < 5; i++) cycle("t1_idle", obs);

    // Single request from source 0.
    set_req(0, AWID'(5), 32'hDEAD_BEEF);
    cycle("t2_single", obs);
    chk("t2_ready0", 64'(obs), 64'd1);
    chk("t2_RFWr", 64'(RFWr), 64'd1);
    chk("t2_rd", 64'(rd), 64'd5);
    chk("t2_DataWr", 64'(DataWr), 64'hDEAD_BEEF);

    // Both sources valid continuously: grants alternate, one write every cycle.
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      if (!req_valid[0]) set_req(0, AWID'(3), $urandom);
      if (!req_valid[1]) set_req(1, AWID'(4), $urandom);
      cycle("t3_both", obs);
      if (i > 0) chk("t3_alternate", 64'(obs ^ prev), 64'd3);
      chk("t3_RFWr", 64'(RFWr), 64'd1);
      prev = obs;
    end
    req_valid = '0;
    cycle("t3_drain", obs);

    // x0 write from source 1: accepted, discarded, pointer moves on to source 0.
    set_req(1, AWID'(0), 32'h0000_1234);
    cycle("t4_x0", obs);
    chk("t4_ready1", 64'(obs), 64'd2);
    chk("t4_RFWr", 64'(RFWr), 64'd0);
    set_req(0, AWID'(11), 32'h0BAD_F00D);
    set_req(1, AWID'(12), 32'h0C0F_FEE0);
    cycle("t4_ptr", obs);
    chk("t4_ptr_next_is_0", 64'(obs), 64'd1);
    cycle("t4_ptr2", obs);

    // Random traffic with per-source hold-until-accepted.
    for (int i = 0; i < 300; i++) begin
      for (int s = 0; s < NREQ; s++)
        if (!req_valid[s] && ($urandom_range(1, 0) == 1))
          set_req(s, AWID'($urandom_range(NREGS - 1, 0)), $urandom);
      cycle("rand", obs);
    end

    // Reset in the middle of traffic: outputs drop immediately, pointer restarts at 0.
    if (!req_valid[0]) set_req(0, AWID'(21), $urandom);
    if (!req_valid[1]) set_req(1, AWID'(22), $urandom);
    cycle("t6_pre", obs);
    if (!req_valid[0]) set_req(0, AWID'(21), $urandom);
    if (!req_valid[1]) set_req(1, AWID'(22), $urandom);
    #1 RST_N = 1'b0;
    #1 check_reset_outs("t6_midstream");
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    reset_model();
`ifdef RF_CLEAR_EN
    for (int i = 0; i < NREGS + 3; i++) cycle("t6_reclear", obs);
`else
    cycle("t6_after", obs);
    chk("t6_ptr_is_0", 64'(obs), 64'd1);
    cycle("t6_after2", obs);
    chk("t6_second_is_1", 64'(obs), 64'd2);
    cycle("t6_after3", obs);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
